// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states and fill values.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // LO is filled with copies of this bit after a divide by zero.
  localparam logic DIV0_LO_FILL_BIT = 1'b1;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module muldiv_divider #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         last_o,
  output logic         ready_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       shifted_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= {W{1'b0}};
      quo_q <= {W{1'b0}};
      dvs_q <= {W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  // The partial remainder never exceeds the divisor, so it fits back into W bits.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    shifted_s = {rem_q, quo_q[W-1]};
    if (start_i) begin
      rem_d = {W{1'b0}};
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(W);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      if (shifted_s >= {1'b0, dvs_q}) begin
        rem_d = W'(shifted_s - {1'b0, dvs_q});
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted_s[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign last_o      = (cnt_q == CNT_W'(1));
  assign ready_o     = (cnt_q == {CNT_W{1'b0}});
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers and hazard stall.
// Define MULDIV_FAST_MULT_EN for a single-busy-cycle multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  Start_IN,
  input  logic [2:0]            Op_IN,
  input  logic [DATA_WIDTH-1:0] OperandA_IN,
  input  logic [DATA_WIDTH-1:0] OperandB_IN,
  input  logic                  ReadHiLo_IN,
  output logic                  Busy_OUT,
  output logic                  Stall_OUT,
  output logic                  Done_OUT,
  output logic                  DivByZero_OUT,
  output logic [DATA_WIDTH-1:0] Hi_OUT,
  output logic [DATA_WIDTH-1:0] Lo_OUT
);

  localparam int W = DATA_WIDTH;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_CYCLES = 1;
`else
  localparam int MUL_CYCLES = MULT_LATENCY;
`endif
  localparam int MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MUL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              signed_q, signed_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic              div0_q, div0_d, dbz_q, dbz_d, done_q, done_d;

  logic              accept_s, is_mul_s, is_div_s, op_signed_div_s;
  logic              busy_s, stall_s, mul_wr_s, fix_wr_s;
  logic [W-1:0]      a_mag_s, b_mag_s, quo_s, rem_s;
  logic              div_last_s, div_ready_s;
  logic [2*W-1:0]    mul_a_s, mul_b_s, prod_s;

  assign accept_s        = (state_q == ST_IDLE) & Start_IN;
  assign is_mul_s        = (Op_IN == OP_MULT) | (Op_IN == OP_MULTU);
  assign is_div_s        = (Op_IN == OP_DIV)  | (Op_IN == OP_DIVU);
  assign op_signed_div_s = (Op_IN == OP_DIV);
  assign a_mag_s = (op_signed_div_s & OperandA_IN[W-1]) ? ({W{1'b0}} - OperandA_IN) : OperandA_IN;
  assign b_mag_s = (op_signed_div_s & OperandB_IN[W-1]) ? ({W{1'b0}} - OperandB_IN) : OperandB_IN;

  muldiv_divider #(.W(W)) u_divider (
    .clk_i       (CLOCK),
    .rst_i       (RESET),
    .start_i     (accept_s & is_div_s),
    .dividend_i  (a_mag_s),
    .divisor_i   (b_mag_s),
    .last_o      (div_last_s),
    .ready_o     (div_ready_s),
    .quotient_o  (quo_s),
    .remainder_o (rem_s)
  );

  assign mul_a_s = {{W{signed_q & a_q[W-1]}}, a_q};
  assign mul_b_s = {{W{signed_q & b_q[W-1]}}, b_q};
  assign prod_s  = mul_a_s * mul_b_s;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s & is_mul_s) begin
          state_d = ST_MUL;
        end else if (accept_s & is_div_s) begin
          state_d = ST_DIV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mcnt_q == {MCNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        if (div_last_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_s   = (state_q != ST_IDLE);
    stall_s  = busy_s & (ReadHiLo_IN | Start_IN);
    mul_wr_s = (state_q == ST_MUL) & (mcnt_q == {MCNT_W{1'b0}});
    fix_wr_s = (state_q == ST_FIX) & div_ready_s;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      hi_q     <= {W{1'b0}};
      lo_q     <= {W{1'b0}};
      mcnt_q   <= {MCNT_W{1'b0}};
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcnt_q   <= mcnt_d;
      signed_q <= signed_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  // Signs are stripped at issue and reapplied in FIX; divide by zero overrides the core result.
  always_comb begin
    a_d = a_q; b_d = b_q; hi_d = hi_q; lo_d = lo_q; mcnt_d = mcnt_q;
    signed_d = signed_q; qneg_d = qneg_q; rneg_d = rneg_q;
    div0_d = div0_q; dbz_d = dbz_q; done_d = 1'b0;
    if (accept_s) begin
      case (Op_IN)
        OP_MTHI: hi_d = OperandA_IN;
        OP_MTLO: lo_d = OperandA_IN;
        OP_MULT, OP_MULTU: begin
          a_d      = OperandA_IN;
          b_d      = OperandB_IN;
          signed_d = (Op_IN == OP_MULT);
          mcnt_d   = MCNT_INIT;
        end
        OP_DIV, OP_DIVU: begin
          a_d      = OperandA_IN;
          b_d      = OperandB_IN;
          signed_d = op_signed_div_s;
          qneg_d   = op_signed_div_s & (OperandA_IN[W-1] ^ OperandB_IN[W-1]);
          rneg_d   = op_signed_div_s & OperandA_IN[W-1];
          div0_d   = (OperandB_IN == {W{1'b0}});
          dbz_d    = dbz_q & (OperandB_IN == {W{1'b0}});
        end
        default: done_d = 1'b0;
      endcase
    end else if (mul_wr_s) begin
      hi_d   = prod_s[2*W-1:W];
      lo_d   = prod_s[W-1:0];
      done_d = 1'b1;
    end else if (fix_wr_s) begin
      if (div0_q) begin
        hi_d  = a_q;
        lo_d  = {W{DIV0_LO_FILL_BIT}};
        dbz_d = 1'b1;
      end else begin
        hi_d = rneg_q ? ({W{1'b0}} - rem_s) : rem_s;
        lo_d = qneg_q ? ({W{1'b0}} - quo_s) : quo_s;
      end
      done_d = 1'b1;
    end else if (state_q == ST_MUL) begin
      mcnt_d = mcnt_q - MCNT_W'(1);
    end else begin
      done_d = 1'b0;
    end
  end

  assign Busy_OUT      = busy_s;
  assign Stall_OUT     = stall_s;
  assign Done_OUT      = done_q;
  assign DivByZero_OUT = dbz_q;
  assign Hi_OUT        = hi_q;
  assign Lo_OUT        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus hand-written hazard and reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MB = 1;
`else
  localparam int MB = 4;
`endif
  localparam int DB = 33;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Start_IN;
  logic [2:0]  Op_IN;
  logic [31:0] OperandA_IN, OperandB_IN;
  logic        ReadHiLo_IN;
  logic        Busy_OUT, Stall_OUT, Done_OUT, DivByZero_OUT;
  logic [31:0] Hi_OUT, Lo_OUT;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.DATA_WIDTH(32), .MULT_LATENCY(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .Start_IN(Start_IN), .Op_IN(Op_IN),
    .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN), .ReadHiLo_IN(ReadHiLo_IN),
    .Busy_OUT(Busy_OUT), .Stall_OUT(Stall_OUT), .Done_OUT(Done_OUT),
    .DivByZero_OUT(DivByZero_OUT), .Hi_OUT(Hi_OUT), .Lo_OUT(Lo_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    Op_IN = v.op; OperandA_IN = v.a; OperandB_IN = v.b; Start_IN = 1'b1;
    tick();
    Start_IN = 1'b0;
    cyc = 0;
    while (Busy_OUT === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    chk($sformatf("v%0d_busy_cycles", idx), 32'(cyc), 32'(v.busy));
    chk($sformatf("v%0d_done", idx), {31'd0, Done_OUT}, 32'd1);
    chk($sformatf("v%0d_hi", idx), Hi_OUT, v.hi);
    chk($sformatf("v%0d_lo", idx), Lo_OUT, v.lo);
    chk($sformatf("v%0d_dbz", idx), {31'd0, DivByZero_OUT}, {31'd0, v.dbz});
    tick();
    chk($sformatf("v%0d_done_drop", idx), {31'd0, Done_OUT}, 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MB, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DB, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DB, 1'b0};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DB, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, DB, 1'b1};
    vecs[6]  = '{OP_DIVU,  32'h00000006, 32'h00000003, 32'h00000000, 32'h00000002, DB, 1'b0};
    vecs[7]  = '{OP_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, MB, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DB, 1'b0};
    vecs[9]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MB, 1'b0};
    vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MB, 1'b0};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, DB, 1'b1};
    vecs[12] = '{OP_DIV,   32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DB, 1'b0};

    RESET = 1'b1; Start_IN = 1'b0; Op_IN = 3'd0;
    OperandA_IN = 32'd0; OperandB_IN = 32'd0; ReadHiLo_IN = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_busy", {31'd0, Busy_OUT}, 32'd0);
    chk("rst_done", {31'd0, Done_OUT}, 32'd0);
    chk("rst_dbz", {31'd0, DivByZero_OUT}, 32'd0);
    chk("rst_hi", Hi_OUT, 32'd0);
    chk("rst_lo", Lo_OUT, 32'd0);
    RESET = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i);
    end

    // MULT 3*5, then MTLO 0x1234 and MFHI held against the busy unit.
    Op_IN = OP_MULT; OperandA_IN = 32'd3; OperandB_IN = 32'd5; Start_IN = 1'b1;
    tick();
    Op_IN = OP_MTLO; OperandA_IN = 32'h00001234; ReadHiLo_IN = 1'b1;
    cyc = 0;
    while (Busy_OUT === 1'b1 && cyc < 200) begin
      chk($sformatf("hz_stall_c%0d", cyc), {31'd0, Stall_OUT}, 32'd1);
      cyc++;
      tick();
    end
    chk("hz_busy_cycles", 32'(cyc), 32'(MB));
    chk("hz_done", {31'd0, Done_OUT}, 32'd1);
    chk("hz_stall_idle", {31'd0, Stall_OUT}, 32'd0);
    chk("hz_lo_mult", Lo_OUT, 32'd15);
    tick();
    Start_IN = 1'b0; ReadHiLo_IN = 1'b0;
    chk("hz_lo_mtlo", Lo_OUT, 32'h00001234);
    chk("hz_hi_kept", Hi_OUT, 32'd0);
    chk("hz_mtlo_nodone", {31'd0, Done_OUT}, 32'd0);
    chk("hz_mtlo_nobusy", {31'd0, Busy_OUT}, 32'd0);

    // Set DivByZero, then abort a division at its tenth cycle with reset.
    run_vec(vecs[5], 50);
    Op_IN = OP_DIV; OperandA_IN = 32'd100; OperandB_IN = 32'd7; Start_IN = 1'b1;
    tick();
    Start_IN = 1'b0;
    repeat (9) tick();
    chk("ar_busy_pre", {31'd0, Busy_OUT}, 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("ar_busy", {31'd0, Busy_OUT}, 32'd0);
    chk("ar_dbz", {31'd0, DivByZero_OUT}, 32'd0);
    chk("ar_hi", Hi_OUT, 32'd0);
    chk("ar_lo", Lo_OUT, 32'd0);
    chk("ar_done", {31'd0, Done_OUT}, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    tick();
    Op_IN = OP_MTHI; OperandA_IN = 32'hA5A5A5A5; Start_IN = 1'b1;
    tick();
    Start_IN = 1'b0;
    chk("ar_mthi_hi", Hi_OUT, 32'hA5A5A5A5);
    chk("ar_mthi_lo", Lo_OUT, 32'd0);
    chk("ar_mthi_done", {31'd0, Done_OUT}, 32'd0);
    chk("ar_mthi_busy", {31'd0, Busy_OUT}, 32'd0);
    tick();
    chk("ar_after_done", {31'd0, Done_OUT}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
